pipe_mem_responder: RTL and testbench
=====================================

// Module: pipe_mem_responder
// PURPOSE
// - Responder for the pipeline's imem/dmem request ports (imem_read; dmem_read/dmem_write).
// - Arbitrates both ports onto a single downstream memory port and returns imem_resp/dmem_resp.
// - Holds each response until the pipeline stage drops its request.
// - Sits between the cpu top and the cache/physical-memory model.
// PARAMETERS
// - ADDR_W  32  byte-address width, all ports
// - DATA_W  32  data width; mbe width is DATA_W/8
// PORTS
// - clk            in   1         clock, all logic on posedge
// - rst            in   1         synchronous, active-high reset
// - imem_read      in   1         IF fetch request, level
// - imem_address   in   ADDR_W    fetch address
// - imem_rdata     out  DATA_W    fetch data, valid while imem_resp
// - imem_resp      out  1         fetch complete, held (see BEHAVIOUR)
// - dmem_read      in   1         MEM load request, level
// - dmem_write     in   1         MEM store request, level
// - dmem_address   in   ADDR_W    load/store address
// - dmem_wdata     in   DATA_W    store data
// - dmem_mbe       in   DATA_W/8  store byte enables
// - dmem_rdata     out  DATA_W    load data, valid while dmem_resp
// - dmem_resp      out  1         load/store complete, held
// - mem_read       out  1         downstream read, registered
// - mem_write      out  1         downstream write, registered
// - mem_address    out  ADDR_W    downstream address, registered
// - mem_wdata      out  DATA_W    downstream write data, registered
// - mem_mbe        out  DATA_W/8  downstream byte enables (all ones on reads)
// - mem_rdata      in   DATA_W    downstream read data, valid with mem_resp
// - mem_resp       in   1         downstream one-cycle completion pulse
// BEHAVIOUR
// Reset values
// - All outputs 0. FSM = IDLE. i_done = d_done = 0. rr_last = IMEM.
// Request protocol
// - A request is pending when it is high and its done flag is clear.
// - After completion, the done flag sets; resp and rdata stay stable while the request stays high.
// - Request low for 1 cycle clears the done flag. Resp falls in the same cycle.
// - A new transaction needs a fresh rising request.
// Issue FSM: IDLE, ISSUE_I, ISSUE_D
// - IDLE with a pending port: latch address/data/mbe, go ISSUE_x.
// - mem_read/mem_write are asserted from the next cycle (1-cycle issue latency).
// - ISSUE_x: hold mem_* stable until mem_resp.
// - On mem_resp: deassert mem_*, capture mem_rdata into the port's rdata register, set x_done, go IDLE.
// - x_resp rises in the cycle after mem_resp (response latency 1 cycle).
// - Minimum round trip: request at cycle 0, mem_* at cycle 1; mem_resp at cycle 1 gives resp at cycle 2.
// - IDLE checks pending ports only, so a held-done port is never reissued.
// Arbitration (both pending in IDLE)
// - dmem wins; it is the older instruction.
// Boundary conditions
// - Request drops while ISSUE_x: the downstream transaction completes, data is discarded, no resp, done flag stays 0.
// - Inputs change mid-issue: ignored; latched copies are used.
// - dmem_read and dmem_write both high: treated as a write; simulation-only assertion fires.
// - mem_resp outside an ISSUE state: ignored.
// - rst mid-transaction: next cycle the FSM is IDLE and all outputs are 0; the downstream is reset concurrently.
// CONFIGURATION
// - PIPE_MEM_RR_ARB_EN defined: round-robin on conflict. The port not served last (rr_last) wins, and rr_last updates on each issue.
// - PIPE_MEM_RR_ARB_EN undefined: fixed dmem priority; the rr_last flop is absent.
// TESTING
// - Single fetch: imem_read=1, addr 0x60, mem_resp 3 cycles after mem_read, mem_rdata 0x00000013
//   -> mem_read high from cycle 1, mem_address 0x60;
//   -> imem_resp=1 and imem_rdata=0x00000013 from the cycle after mem_resp until imem_read drops.
// - Store: dmem_write=1, addr 0x1004, wdata 0xDEADBEEF, mbe 0x3
//   -> mem_write=1 with mem_mbe=0x3 and the same data;
//   -> dmem_resp held, dmem_rdata unchanged.
// - Conflict: imem_read and dmem_read rise the same cycle
//   -> fixed: dmem issued first, then imem;
//   -> RR_EN: alternates over 4 back-to-back conflicts (D,I,D,I from reset, since rr_last=IMEM).
// - Held resp: imem_read kept high 5 cycles after imem_resp
//   -> exactly one mem_read transaction; imem_resp high all 5 cycles;
//   -> drop 1 cycle and re-raise -> a second transaction issues.
// - Abort: imem_read dropped while ISSUE_I
//   -> the mem transaction completes, imem_resp never asserts;
//   -> a pending dmem issues in the next IDLE cycle.
// - Reset mid-op: rst=1 during ISSUE_D -> next cycle mem_write=0, dmem_resp=0, FSM IDLE.

Source files
------------

// File: rtl/pipe_mem_responder_if.sv
// pipe_mem_responder_if: pipeline imem/dmem request ports plus the single downstream memory port.
// Parameters: ADDR_W byte-address width, DATA_W data width (byte enables are DATA_W/8 wide).
// slave: responder view (takes requests and mem_rdata/mem_resp, drives responses and mem_*).
// master: environment view (pipeline stages and memory model).
interface pipe_mem_responder_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic imem_read;
  logic [ADDR_W-1:0] imem_address;
  logic [DATA_W-1:0] imem_rdata;
  logic imem_resp;
  logic dmem_read;
  logic dmem_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W/8-1:0] dmem_mbe;
  logic [DATA_W-1:0] dmem_rdata;
  logic dmem_resp;
  logic mem_read;
  logic mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_mbe;
  logic [DATA_W-1:0] mem_rdata;
  logic mem_resp;
  modport slave (
    input imem_read, imem_address, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input mem_rdata, mem_resp,
    output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata, mem_mbe
  );
  modport master (
    output imem_read, imem_address, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output mem_rdata, mem_resp,
    input imem_rdata, imem_resp, dmem_rdata, dmem_resp,
    input mem_read, mem_write, mem_address, mem_wdata, mem_mbe
  );
endinterface

// File: rtl/pipe_mem_responder.sv
// pipe_mem_responder: arbitrates pipeline imem/dmem requests onto one downstream memory port.
// Ports: clk, rst (sync, active high), bus (pipe_mem_responder_if.slave: imem_*/dmem_* request
// and held-response signals, registered mem_* downstream outputs, mem_rdata/mem_resp inputs).
// Widths follow the interface parameters. Define PIPE_MEM_RR_ARB_EN for round-robin arbitration
// on conflicts; otherwise dmem always wins.
module pipe_mem_responder (
  input logic clk,
  input logic rst,
  pipe_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE_I, ISSUE_D} state_t;
  state_t state, state_n;
  logic i_done, d_done, i_req, d_req, pend_i, pend_d, pick_d, issue, fin_i, fin_d;
  assign i_req = bus.imem_read;
  assign d_req = bus.dmem_read | bus.dmem_write;
  assign pend_i = i_req & ~i_done;
  assign pend_d = d_req & ~d_done;
`ifdef PIPE_MEM_RR_ARB_EN
  // set when dmem was the most recently issued port
  logic rr_last;
  always_ff @(posedge clk)
    if (rst) rr_last <= 1'b0;
    else if (issue) rr_last <= pick_d;
  assign pick_d = pend_d & (~pend_i | ~rr_last);
`else
  assign pick_d = pend_d;
`endif
  always_comb begin
    issue = state == IDLE && (pend_i || pend_d);
    fin_i = state == ISSUE_I && bus.mem_resp;
    fin_d = state == ISSUE_D && bus.mem_resp;
    state_n = state == IDLE ? (pick_d ? ISSUE_D : pend_i ? ISSUE_I : IDLE) : bus.mem_resp ? IDLE : state;
  end
  // done only sets if the request is still up when the downstream completes, so aborted
  // transactions never raise a response; dropping the request clears it
  assign bus.imem_resp = i_done & i_req;
  assign bus.dmem_resp = d_done & d_req;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i_done <= 1'b0;
      d_done <= 1'b0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata <= '0;
      bus.mem_mbe <= '0;
      bus.imem_rdata <= '0;
      bus.dmem_rdata <= '0;
    end else begin
      state <= state_n;
      i_done <= i_req & (i_done | fin_i);
      d_done <= d_req & (d_done | fin_d);
      if (issue) begin
        bus.mem_read <= ~(pick_d & bus.dmem_write);
        bus.mem_write <= pick_d & bus.dmem_write;
        bus.mem_address <= pick_d ? bus.dmem_address : bus.imem_address;
        bus.mem_wdata <= pick_d ? bus.dmem_wdata : '0;
        bus.mem_mbe <= pick_d & bus.dmem_write ? bus.dmem_mbe : '1;
      end else if (fin_i | fin_d) begin
        bus.mem_read <= 1'b0;
        bus.mem_write <= 1'b0;
      end
      if (fin_i & i_req) bus.imem_rdata <= bus.mem_rdata;
      if (fin_d & d_req & bus.mem_read) bus.dmem_rdata <= bus.mem_rdata;
    end
  end
`ifndef SYNTHESIS
  a_rw_excl: assert property (@(posedge clk) disable iff (rst) !(bus.dmem_read && bus.dmem_write))
    else $error("dmem_read and dmem_write both high");
`endif
endmodule

// File: tb/tb_pipe_mem_responder.sv
// tb_pipe_mem_responder: vector table, corner sequences and random episodes against a transaction-level model.
module tb_pipe_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pipe_mem_responder_if bus ();
  pipe_mem_responder dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic wr; logic [31:0] a; logic [31:0] d; logic [3:0] be; logic port;} txn_t;
  typedef struct {bit d; bit wr; logic [31:0] a; logic [31:0] wd; logic [3:0] be; int lat;
                  bit e_rd; bit e_wr; logic [3:0] e_be; logic [31:0] e_rdata;} vec_t;
  int n_vec = 0, n_err = 0;
  int lat = 0, cnt = -1;
  txn_t log[$];
  txn_t mt;
  logic [31:0] ram [logic [31:0]];
  logic [31:0] sh [logic [31:0]];
  logic [31:0] exp_i_rd = 0, exp_d_rd = 0;
  bit last_d = 0;
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction
  function automatic logic [31:0] ram_rd(logic [31:0] a);
    return ram.exists(a) ? ram[a] : ~a;
  endfunction
  function automatic logic [31:0] sh_rd(logic [31:0] a);
    return sh.exists(a) ? sh[a] : ~a;
  endfunction
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  // downstream memory: latency counted from first sight of mem_read/mem_write, one-cycle mem_resp
  always @(negedge clk) begin
    if (rst || bus.mem_resp) begin
      bus.mem_resp = 1'b0;
      cnt = -1;
    end else if (bus.mem_read || bus.mem_write) begin
      if (cnt < 0) cnt = lat < 0 ? int'($urandom_range(0, 3)) : lat;
      if (cnt == 0) begin
        mt = '{wr: bus.mem_write, a: bus.mem_address, d: bus.mem_wdata, be: bus.mem_mbe, port: 1'b0};
        log.push_back(mt);
        if (bus.mem_write) begin
          ram[mt.a] = merge(ram_rd(mt.a), mt.d, mt.be);
          bus.mem_rdata = $urandom;
        end else bus.mem_rdata = ram_rd(mt.a);
        bus.mem_resp = 1'b1;
      end else cnt--;
    end
  end
  // mode 0: imem only, 1: dmem only, 2: both raised together
  task automatic episode(input int mode, input logic [31:0] ia, input bit dw, input logic [31:0] da,
                         input logic [31:0] wd, input logic [3:0] be, input int hold);
    txn_t q[$];
    txn_t ti, td;
    bit ui, ud, dfirst, ok;
    int base, h;
    ui = mode != 1;
    ud = mode != 0;
`ifdef PIPE_MEM_RR_ARB_EN
    dfirst = ud && (!ui || !last_d);
`else
    dfirst = ud;
`endif
    ti = '{wr: 1'b0, a: ia, d: 32'h0, be: 4'hF, port: 1'b0};
    td = '{wr: dw, a: da, d: wd, be: dw ? be : 4'hF, port: 1'b1};
    if (dfirst) begin
      q.push_back(td);
      if (ui) q.push_back(ti);
    end else begin
      if (ui) q.push_back(ti);
      if (ud) q.push_back(td);
    end
    foreach (q[j]) begin
      if (q[j].wr) sh[q[j].a] = merge(sh_rd(q[j].a), q[j].d, q[j].be);
      else if (q[j].port) exp_d_rd = sh_rd(q[j].a);
      else exp_i_rd = sh_rd(q[j].a);
      last_d = q[j].port;
    end
    base = log.size();
    bus.imem_read = ui;
    bus.imem_address = ia;
    bus.dmem_read = ud & !dw;
    bus.dmem_write = ud & dw;
    bus.dmem_address = da;
    bus.dmem_wdata = wd;
    bus.dmem_mbe = be;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      cyc();
      ok = (!ui || bus.imem_resp) && (!ud || bus.dmem_resp);
    end
    chk("resp_rise", ok, 1);
    chk("txn_count", log.size(), base + q.size());
    if (log.size() >= base + q.size())
      foreach (q[j]) begin
        chk("txn_op", log[base+j].wr, q[j].wr);
        chk("txn_addr", log[base+j].a, q[j].a);
        chk("txn_mbe", log[base+j].be, q[j].be);
        if (q[j].wr) chk("txn_wdata", log[base+j].d, q[j].d);
      end
    chk("imem_rdata", bus.imem_rdata, exp_i_rd);
    chk("dmem_rdata", bus.dmem_rdata, exp_d_rd);
    h = hold < 0 ? int'($urandom_range(0, 3)) : hold;
    repeat (h) begin
      cyc();
      chk("resp_held", {bus.imem_resp, bus.dmem_resp}, {ui, ud});
    end
    chk("no_reissue", log.size(), base + q.size());
    bus.imem_read = 0;
    bus.dmem_read = 0;
    bus.dmem_write = 0;
    cyc();
    chk("resp_fall", {bus.imem_resp, bus.dmem_resp}, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tv[6];
    int base;
    bit ok, saw_i;
    tv[0] = '{0, 0, 32'h60,   32'h0,        4'h0, 3, 1, 0, 4'hF, 32'h00000013};
    tv[1] = '{1, 1, 32'h1004, 32'hDEADBEEF, 4'h3, 1, 0, 1, 4'h3, 32'h00000000};
    tv[2] = '{1, 0, 32'h1004, 32'h0,        4'h0, 0, 1, 0, 4'hF, 32'h1122BEEF};
    tv[3] = '{0, 0, 32'h64,   32'h0,        4'h0, 0, 1, 0, 4'hF, 32'h00100093};
    tv[4] = '{1, 1, 32'h8,    32'hCAFEF00D, 4'hF, 2, 0, 1, 4'hF, 32'h1122BEEF};
    tv[5] = '{1, 0, 32'h8,    32'h0,        4'h0, 1, 1, 0, 4'hF, 32'hCAFEF00D};
    ram[32'h60] = 32'h13; ram[32'h64] = 32'h00100093; ram[32'h1004] = 32'h11223344;
    sh = ram;
    rst = 1;
    bus.imem_read = 0; bus.imem_address = 0;
    bus.dmem_read = 0; bus.dmem_write = 0; bus.dmem_address = 0; bus.dmem_wdata = 0; bus.dmem_mbe = 0;
    bus.mem_rdata = 0; bus.mem_resp = 0;
    cyc(); cyc();
    chk("rst_mem_ctl", {bus.mem_read, bus.mem_write, bus.mem_mbe}, 0);
    chk("rst_mem_addr", {bus.mem_address, bus.mem_wdata}, 0);
    chk("rst_resp", {bus.imem_resp, bus.dmem_resp}, 0);
    chk("rst_rdata", {bus.imem_rdata, bus.dmem_rdata}, 0);
    rst = 0;
    cyc();
    foreach (tv[r]) begin
      lat = tv[r].lat;
      base = log.size();
      bus.imem_read = !tv[r].d;
      bus.imem_address = tv[r].a;
      bus.dmem_read = tv[r].d & !tv[r].wr;
      bus.dmem_write = tv[r].d & tv[r].wr;
      bus.dmem_address = tv[r].a;
      bus.dmem_wdata = tv[r].wd;
      bus.dmem_mbe = tv[r].be;
      cyc();
      chk("issue_rd", bus.mem_read, tv[r].e_rd);
      chk("issue_wr", bus.mem_write, tv[r].e_wr);
      chk("issue_addr", bus.mem_address, tv[r].a);
      chk("issue_mbe", bus.mem_mbe, tv[r].e_be);
      if (tv[r].wr) chk("issue_wdata", bus.mem_wdata, tv[r].wd);
      ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
        cyc();
        ok = tv[r].d ? bus.dmem_resp : bus.imem_resp;
      end
      chk("vec_resp", ok, 1);
      chk("vec_rdata", tv[r].d ? bus.dmem_rdata : bus.imem_rdata, tv[r].e_rdata);
      repeat (5) begin
        cyc();
        chk("vec_held", tv[r].d ? bus.dmem_resp : bus.imem_resp, 1);
      end
      chk("vec_txns", log.size(), base + 1);
      if (tv[r].wr) sh[tv[r].a] = merge(sh_rd(tv[r].a), tv[r].wd, tv[r].be);
      else if (tv[r].d) exp_d_rd = tv[r].e_rdata;
      else exp_i_rd = tv[r].e_rdata;
      last_d = tv[r].d;
      bus.imem_read = 0; bus.dmem_read = 0; bus.dmem_write = 0;
      cyc();
      chk("vec_fall", {bus.imem_resp, bus.dmem_resp}, 0);
    end
    lat = 1;
    episode(0, 32'h64, 0, 0, 0, 0, 5);
    episode(0, 32'h64, 0, 0, 0, 0, 5);
    lat = 0;
    repeat (4) episode(2, 32'h60, 0, 32'h1004, 0, 0, 1);
    episode(2, 32'h8, 1, 32'h8, 32'h12345678, 4'hF, 0);
    episode(1, 0, 1, 32'h10, 32'hA5A5A5A5, 4'h6, 0);
    episode(2, 32'h10, 0, 32'h10, 0, 0, 0);
    lat = 4;
    base = log.size();
    bus.imem_read = 1; bus.imem_address = 32'h60;
    cyc();
    chk("abort_issue", bus.mem_read, 1);
    bus.imem_read = 0;
    bus.dmem_read = 1; bus.dmem_address = 32'h8;
    saw_i = 0; ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      cyc();
      saw_i |= bus.imem_resp;
      ok = bus.dmem_resp;
    end
    chk("abort_dresp", ok, 1);
    chk("abort_no_iresp", saw_i, 0);
    chk("abort_txns", log.size(), base + 2);
    if (log.size() >= base + 2) begin
      chk("abort_first", {log[base].wr, log[base].a}, {1'b0, 32'h60});
      chk("abort_second", {log[base+1].wr, log[base+1].a}, {1'b0, 32'h8});
    end
    exp_d_rd = sh_rd(32'h8);
    last_d = 1;
    chk("abort_drdata", bus.dmem_rdata, exp_d_rd);
    chk("abort_irdata", bus.imem_rdata, exp_i_rd);
    bus.dmem_read = 0;
    cyc();
    lat = 10;
    bus.dmem_write = 1; bus.dmem_address = 32'h10; bus.dmem_wdata = 32'h55; bus.dmem_mbe = 4'hF;
    cyc();
    chk("rstop_issue", bus.mem_write, 1);
    cyc();
    rst = 1;
    cyc();
    chk("rstop_mem", {bus.mem_read, bus.mem_write}, 0);
    chk("rstop_resp", bus.dmem_resp, 0);
    chk("rstop_rdata", {bus.imem_rdata, bus.dmem_rdata}, 0);
    rst = 0;
    bus.dmem_write = 0;
    exp_i_rd = 0; exp_d_rd = 0; last_d = 0;
    cyc(); cyc();
    lat = -1;
    repeat (60)
      episode(int'($urandom_range(0, 2)), 32'($urandom_range(0, 7)) * 4, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 7)) * 4, $urandom, 4'($urandom_range(1, 15)), -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
